// File: rtl/discrete_audio_pkg.sv
// rtl/discrete_audio_pkg.sv - shared types, fixed-point shifts and saturation helper for discrete audio blocks
package discrete_audio_pkg;

   typedef logic signed [15:0] sample_t;

   // Fixed-point scaling used when deriving filter coefficients and sub-step products
   localparam int DT_SHIFT    = 32;
   localparam int RC_SHIFT    = 35;
   localparam int ALPHA_SHIFT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } hpf_state_e;

   // Clamp a wide signed intermediate to the 16-bit sample range
   function automatic sample_t saturate16(input logic signed [34:0] v);
      sample_t r;
      if (v > 35'sd32767) begin
         r = 16'sh7fff;
      end else if (v < -35'sd32768) begin
         r = 16'sh8000;
      end else begin
         r = sample_t'(v);
      end
      return r;
   endfunction

endpackage

// File: rtl/hpf_step_datapath.sv
// rtl/hpf_step_datapath.sv - combinational RC high-pass Euler sub-step; build option RC_HPF_SATURATE_EN
module hpf_step_datapath
   import discrete_audio_pkg::*;
#(
   parameter logic [16:0] ALPHA = 17'd65458
) (
   input  sample_t            y,
   input  logic signed [16:0] dx,
   output sample_t            y_next
);

   logic signed [17:0] s;
   logic signed [34:0] s_ext;
   logic signed [34:0] alpha_ext;
   logic signed [34:0] p_shr;

   // y_next = alpha * (y + dx); alpha is an unsigned Q0.16 fraction
   always_comb begin
      s         = {{2{y[15]}}, y} + {dx[16], dx};
      s_ext     = {{17{s[17]}}, s};
      alpha_ext = {18'd0, ALPHA};
      p_shr     = (s_ext * alpha_ext) >>> ALPHA_SHIFT;
`ifdef RC_HPF_SATURATE_EN
      y_next    = saturate16(p_shr);
`else
      // Wrap to 16 bits instead of clamping
      y_next    = sample_t'(p_shr);
`endif
   end

endmodule

// File: rtl/resistor_capacitor_high_pass_filter.sv
// rtl/resistor_capacitor_high_pass_filter.sv - oversampled RC high-pass stage; build option RC_HPF_SATURATE_EN
module resistor_capacitor_high_pass_filter
   import discrete_audio_pkg::*;
#(
   parameter int     CLOCK_RATE   = 50000000,
   parameter int     SAMPLE_RATE  = 48000,
   parameter int     OVERSAMPLE   = 8,
   parameter longint R            = 47000,
   parameter longint C_35_SHIFTED = 1615
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               audio_clk_en,
   input  logic signed [15:0] in,
   output logic signed [15:0] out,
   output logic               out_valid,
   output logic               busy,
   output logic               overrun
);

   localparam longint DELTA_T_32_SHIFTED =
      (longint'(1) <<< DT_SHIFT) / (longint'(SAMPLE_RATE) * longint'(OVERSAMPLE));
   localparam longint R_C_32_SHIFTED   = (R * C_35_SHIFTED) >>> (RC_SHIFT - DT_SHIFT);
   localparam longint ALPHA_16_SHIFTED =
      (R_C_32_SHIFTED <<< ALPHA_SHIFT) / (R_C_32_SHIFTED + DELTA_T_32_SHIFTED);
   localparam logic [16:0] ALPHA_17  = ALPHA_16_SHIFTED[16:0];
   localparam int          K_W       = 6;
   localparam logic [K_W-1:0] K_LAST = K_W'(OVERSAMPLE - 1);

   // Need OVERSAMPLE sub-steps plus load/done overhead inside one sample period
   if (CLOCK_RATE / SAMPLE_RATE < OVERSAMPLE + 3) begin : g_rate_check
      $error("CLOCK_RATE/SAMPLE_RATE too small for OVERSAMPLE");
   end
   if (OVERSAMPLE < 1 || OVERSAMPLE > 64) begin : g_os_check
      $error("OVERSAMPLE must be in 1..64");
   end

   hpf_state_e         state_q, state_d;
   logic [K_W-1:0]     k_q, k_d;
   sample_t            x_cur_q, x_cur_d;
   sample_t            x_prev_q, x_prev_d;
   sample_t            y_q, y_d;
   sample_t            out_q, out_d;
   logic               out_valid_q, out_valid_d;
   logic               pending_q, pending_d;
   sample_t            pend_data_q, pend_data_d;
   logic               overrun_q, overrun_d;
   logic signed [16:0] dx;
   sample_t            y_step;

   // Input difference only enters on the first sub-step of each sample
   assign dx = (k_q == '0) ? ({x_cur_q[15], x_cur_q} - {x_prev_q[15], x_prev_q}) : '0;

   hpf_step_datapath #(
      .ALPHA (ALPHA_17)
   ) u_step (
      .y      (y_q),
      .dx     (dx),
      .y_next (y_step)
   );

   // State and data registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         x_cur_q     <= '0;
         x_prev_q    <= '0;
         y_q         <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         pending_q   <= 1'b0;
         pend_data_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         x_cur_q     <= x_cur_d;
         x_prev_q    <= x_prev_d;
         y_q         <= y_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         pending_q   <= pending_d;
         pend_data_q <= pend_data_d;
         overrun_q   <= overrun_d;
      end
   end

   // Next-state: start on strobe or pending sample, run sub-steps, then publish
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pending_q || audio_clk_en) state_d = STEP;
         STEP:    if (k_q == K_LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates: sample load, sub-step accumulate, publish, pending slot
   always_comb begin
      k_d         = k_q;
      x_cur_d     = x_cur_q;
      x_prev_d    = x_prev_q;
      y_d         = y_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      pending_d   = pending_q;
      pend_data_d = pend_data_q;
      overrun_d   = overrun_q;
      case (state_q)
         IDLE: begin
            if (pending_q) begin
               // Pending sample has priority; a simultaneous strobe refills the slot
               x_cur_d   = pend_data_q;
               k_d       = '0;
               pending_d = audio_clk_en;
               if (audio_clk_en) pend_data_d = in;
            end else if (audio_clk_en) begin
               x_cur_d = in;
               k_d     = '0;
            end
         end
         STEP: begin
            y_d = y_step;
            k_d = k_q + K_W'(1);
         end
         DONE: begin
            out_d       = y_q;
            out_valid_d = 1'b1;
            x_prev_d    = x_cur_q;
         end
         default: ;
      endcase
      if (state_q != IDLE && audio_clk_en) begin
         if (pending_q) overrun_d = 1'b1;
         pending_d   = 1'b1;
         pend_data_d = in;
      end
   end

   // Outputs straight from registers
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != IDLE);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_resistor_capacitor_high_pass_filter.sv
// tb/tb_resistor_capacitor_high_pass_filter.sv - scoreboard bench for the RC high-pass stage
module tb_resistor_capacitor_high_pass_filter;

   localparam int     OS     = 8;
   localparam longint RC_32  = (64'sd47000 * 64'sd1615) >>> 3;
   localparam longint DT_OS8 = (64'sd1 <<< 32) / (64'sd48000 * 64'sd8);
   localparam longint DT_OS1 = (64'sd1 <<< 32) / 64'sd48000;
   localparam longint ALPHA8 = (RC_32 <<< 16) / (RC_32 + DT_OS8);
   localparam longint ALPHA1 = (RC_32 <<< 16) / (RC_32 + DT_OS1);

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               en = 1'b0;
   logic signed [15:0] in_s = '0;
   logic signed [15:0] out;
   logic               out_valid, busy, overrun;
   logic               en1 = 1'b0;
   logic signed [15:0] in1 = '0;
   logic signed [15:0] out1;
   logic               out1_valid, busy1, overrun1;

   int                 vectors = 0;
   int                 miscompares = 0;
   logic signed [15:0] exp_q[$];
   logic signed [15:0] mon_e;
   longint             y_m = 0;
   longint             xp_m = 0;
   int                 n;

   always #5 clk = ~clk;

   resistor_capacitor_high_pass_filter dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .audio_clk_en (en),
      .in           (in_s),
      .out          (out),
      .out_valid    (out_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   resistor_capacitor_high_pass_filter #(.OVERSAMPLE(1)) dut1 (
      .clk          (clk),
      .reset_n      (reset_n),
      .audio_clk_en (en1),
      .in           (in1),
      .out          (out1),
      .out_valid    (out1_valid),
      .busy         (busy1),
      .overrun      (overrun1)
   );

   task automatic check(input string name, input longint act, input longint req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic longint sub_step(input longint y, input longint dx, input longint a);
      longint q;
      q = ((y + dx) * a) >>> 16;
`ifdef RC_HPF_SATURATE_EN
      if (q > 32767) q = 32767;
      else if (q < -32768) q = -32768;
`else
      q = longint'($signed(q[15:0]));
`endif
      return q;
   endfunction

   task automatic expect_sample(input longint x);
      longint dx;
      dx = x - xp_m;
      for (int i = 0; i < OS; i++) y_m = sub_step(y_m, (i == 0) ? dx : 0, ALPHA8);
      xp_m = x;
      exp_q.push_back(16'(y_m));
   endtask

   always @(negedge clk) begin
      if (reset_n && out_valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_out_valid: got out=%0d, expected no output", out);
         end else begin
            mon_e = exp_q.pop_front();
            check("out", out, mon_e);
         end
      end
   end

   task automatic tick(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input longint x);
      en   = 1'b1;
      in_s = 16'(x);
      @(posedge clk);
      #1;
      en   = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         tick(1);
         c++;
      end
      tick(2);
      check("drain_pending", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      y_m     = 0;
      xp_m    = 0;
      in_s    = 16'sd12345;
      for (int i = 0; i < 6; i++) begin
         en = (i % 3 == 0);
         @(posedge clk);
         #1;
         check("reset_out", out, 0);
         check("reset_flags", {out_valid, overrun, busy}, 0);
      end
      en      = 1'b0;
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      do_reset();

      // OVERSAMPLE=1 instance: single sub-step, output two cycles after strobe
      en1 = 1'b1;
      in1 = 16'sd1000;
      @(posedge clk);
      #1;
      en1 = 1'b0;
      tick(1);
      check("os1_valid_early", out1_valid, 0);
      tick(1);
      check("os1_valid", out1_valid, 1);
      check("os1_out", out1, (64'sd1000 * ALPHA1) >>> 16);

      // Step 0 -> 10000 with latency measurement, then decay on held input
      tick(3);
      expect_sample(10000);
      strobe(10000);
      for (n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (out_valid) break;
      end
      check("latency", n, 9);
      tick(3);
      expect_sample(10000);
      strobe(10000);
      wait_drain(30);
      expect_sample(10000);
      strobe(10000);
      wait_drain(30);
      check("no_overrun_step", overrun, 0);

      // Full-scale swing: 32767 then -32768
      do_reset();
      expect_sample(32767);
      strobe(32767);
      wait_drain(30);
      expect_sample(-32768);
      strobe(-32768);
      wait_drain(30);

      // Reset while sub-steps are running (k==4)
      strobe(10000);
      tick(4);
      reset_n = 1'b0;
      tick(1);
      check("midreset_busy", busy, 0);
      check("midreset_out", out, 0);
      check("midreset_valid", out_valid, 0);
      reset_n = 1'b1;
      y_m     = 0;
      xp_m    = 0;
      tick(2);
      expect_sample(10000);
      strobe(10000);
      wait_drain(30);

      // Pending slot and overrun
      do_reset();
      expect_sample(5000);
      strobe(5000);
      tick(2);
      strobe(-3000);
      check("overrun_after_pending", overrun, 0);
      tick(1);
      strobe(7000);
      expect_sample(7000);
      check("overrun_set", overrun, 1);
      wait_drain(60);
      check("overrun_sticky", overrun, 1);

      // Strobe landing in the DONE cycle
      expect_sample(2000);
      strobe(2000);
      tick(8);
      expect_sample(-1500);
      strobe(-1500);
      wait_drain(60);
      check("overrun_still_set", overrun, 1);

      do_reset();
      tick(2);
      check("overrun_cleared", overrun, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
